// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types for the matrix-keypad scanner:
//   kpd_state_e  - debounce FSM states
//   kpd_frame_e  - result of one full column scan (frame)
//   kpd_code_w() - width of a key index for an N_ROWS x N_COLS matrix
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } kpd_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } kpd_frame_e;

    function automatic int kpd_code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/kpd_col_scan.sv
// ----------------------------------------------------------------------------
// kpd_col_scan
// Column strobe generator and per-frame row evaluation.
// Each column is driven low for SCAN_DIV clocks; the (already synchronised)
// rows are sampled on the last dwell clock. After the last column the frame
// result (NONE / ONE / MULTI) and the key code are presented combinationally
// for exactly one clock, qualified by o_frame_done.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_rows         synchronised row lines, active-low
//   o_cols         column strobes, active-low one-hot ('1 in reset)
//   o_frame_done   1 on the last sample cycle of a frame
//   o_result       frame result, valid with o_frame_done
//   o_code         key index row*N_COLS+col, meaningful when o_result==ONE
// ----------------------------------------------------------------------------
module kpd_col_scan
    import keypad_pkg::*;
#(
    parameter int N_ROWS   = 4,
    parameter int N_COLS   = 4,
    parameter int SCAN_DIV = 50,
    localparam int CW      = kpd_code_w(N_ROWS, N_COLS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_ROWS-1:0] i_rows,
    output logic [N_COLS-1:0] o_cols,
    output logic              o_frame_done,
    output kpd_frame_e        o_result,
    output logic [CW-1:0]     o_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(N_COLS);
    localparam int ROW_W = $clog2(N_ROWS);

    logic [DIV_W-1:0]  r_div;
    logic [COL_W-1:0]  r_col;
    logic [N_COLS-1:0] r_cols;
    logic [1:0]        r_low_cnt;   // low bits seen so far this frame, saturates at 2
    logic [CW-1:0]     r_code;

    logic              w_last_div;
    logic              w_last_col;
    logic [COL_W-1:0]  w_col_nxt;
    logic [N_COLS-1:0] w_cols_nxt;
    logic [1:0]        w_col_cnt;
    logic [1:0]        w_tot;
    logic [ROW_W-1:0]  w_row_idx;
    logic [CW-1:0]     w_code_acc;

    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    assign w_last_div = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_last_col = (r_col == COL_W'(N_COLS - 1));

    // The strobe is registered from the next column index so it changes on the
    // same edge as r_col and never glitches.
    always_comb begin
        w_col_nxt = r_col;
        if (w_last_div) begin
            w_col_nxt = w_last_col ? '0 : r_col + 1'b1;
        end
        for (int c = 0; c < N_COLS; c++) begin
            w_cols_nxt[c] = (COL_W'(c) != w_col_nxt);
        end
    end

    always_comb begin
        w_col_cnt = 2'd0;
        w_row_idx = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (!i_rows[r]) begin
                w_row_idx = ROW_W'(r);
                if (w_col_cnt != 2'd2) begin
                    w_col_cnt = w_col_cnt + 2'd1;
                end
            end
        end
    end

    assign w_tot = sat_add(r_low_cnt, w_col_cnt);

    // The code only matters when the frame total is exactly one low bit, so it
    // is either the stored one or the one in the current column.
    assign w_code_acc = (r_low_cnt == 2'd0 && w_col_cnt == 2'd1)
                      ? CW'(int'(w_row_idx) * N_COLS + int'(r_col))
                      : r_code;

    always_comb begin
        o_result = MULTI;
        if (w_tot == 2'd0) begin
            o_result = NONE;
        end else if (w_tot == 2'd1) begin
            o_result = ONE;
        end
    end

    assign o_frame_done = w_last_div & w_last_col;
    assign o_code       = w_code_acc;
    assign o_cols       = r_cols;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_col     <= '0;
            r_cols    <= '1;
            r_low_cnt <= 2'd0;
            r_code    <= '0;
        end else begin
            r_col  <= w_col_nxt;
            r_cols <= w_cols_nxt;
            if (w_last_div) begin
                r_div <= '0;
                if (w_last_col) begin
                    r_low_cnt <= 2'd0;
                    r_code    <= '0;
                end else begin
                    r_low_cnt <= w_tot;
                    r_code    <= w_code_acc;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
// Matrix-keypad scanner: strobes columns, samples rows through a 2-flop
// synchroniser, debounces whole-frame results, rejects multi-key frames and
// delivers one key event per press through a 1-entry valid/ready register.
// Optional feature: define KPD_REPEAT_EN to generate auto-repeat events
// (first after REP_DELAY held frames, then every REP_RATE frames).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   filas        row lines, active-low, asynchronous
//   columnas     column strobes, active-low one-hot
//   key_code     key index row*N_COLS+col, stable while key_valid
//   key_valid    event pending
//   key_ready    consumer accepts when key_valid & key_ready
//   key_down     a confirmed key is held (PRESSED or releasing)
//   key_overrun  1-clk pulse: event dropped because the holding reg was full
// ----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int SCAN_DIV   = 50,
    parameter int DEB_FRAMES = 3,
    parameter int REP_DELAY  = 20,
    parameter int REP_RATE   = 5,
    localparam int CW        = kpd_code_w(N_ROWS, N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] filas,
    output logic [N_COLS-1:0] columnas,
    output logic [CW-1:0]     key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic              key_overrun
);

    localparam int CNT_W = $clog2(DEB_FRAMES + 1);

    if (N_ROWS < 2 || N_COLS < 2 || SCAN_DIV < 2 || DEB_FRAMES < 1 ||
        REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    logic [N_ROWS-1:0] r_filas_s1;
    logic [N_ROWS-1:0] r_filas_s2;

    kpd_state_e        r_state;
    kpd_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CW-1:0]     r_cand;
    logic [CW-1:0]     w_cand_nxt;

    logic              w_frame_done;
    kpd_frame_e        w_result;
    logic [CW-1:0]     w_code;
    logic              w_one_cand;
    logic              w_cnt_hit;
    logic              w_press_event;
    logic              w_event;

    logic              r_key_valid;
    logic              r_key_overrun;
    logic [CW-1:0]     r_key_code;
    logic              w_handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filas_s1 <= '1;
            r_filas_s2 <= '1;
        end else begin
            r_filas_s1 <= filas;
            r_filas_s2 <= r_filas_s1;
        end
    end

    kpd_col_scan #(
        .N_ROWS   (N_ROWS),
        .N_COLS   (N_COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rows       (r_filas_s2),
        .o_cols       (columnas),
        .o_frame_done (w_frame_done),
        .o_result     (w_result),
        .o_code       (w_code)
    );

    assign w_one_cand = (w_result == ONE) && (w_code == r_cand);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cnt_hit  = (w_cnt_inc == CNT_W'(DEB_FRAMES));

    // Debounce FSM: only moves on frame boundaries.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cand_nxt    = r_cand;
        w_press_event = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_result == ONE) begin
                        w_cand_nxt = w_code;
                        if (DEB_FRAMES == 1) begin
                            w_state_nxt   = PRESSED;
                            w_press_event = 1'b1;
                        end else begin
                            w_state_nxt = PRESS_DB;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (w_one_cand) begin
                        if (w_cnt_hit) begin
                            w_state_nxt   = PRESSED;
                            w_cnt_nxt     = '0;
                            w_press_event = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                PRESSED: begin
                    if (!w_one_cand) begin
                        if (DEB_FRAMES == 1) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = REL_DB;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                REL_DB: begin
                    if (w_one_cand) begin
                        // Bounce during release: resume holding, no new event.
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_hit) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

`ifdef KPD_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
    logic [REP_W-1:0] w_rep_inc;
    logic [REP_W-1:0] w_rep_lim;
    logic             r_rep_first;
    logic             w_rep_first_nxt;
    logic             w_rep_event;

    // Counts frames held in PRESSED; any (re)entry into PRESSED restarts the
    // delay, including a return from a bouncing release.
    always_comb begin
        w_rep_nxt       = r_rep;
        w_rep_first_nxt = r_rep_first;
        w_rep_event     = 1'b0;
        w_rep_inc       = r_rep + 1'b1;
        w_rep_lim       = r_rep_first ? REP_W'(REP_DELAY) : REP_W'(REP_RATE);
        if (w_frame_done && w_state_nxt == PRESSED) begin
            if (r_state != PRESSED) begin
                w_rep_nxt       = '0;
                w_rep_first_nxt = 1'b1;
            end else if (w_rep_inc == w_rep_lim) begin
                w_rep_nxt       = '0;
                w_rep_first_nxt = 1'b0;
                w_rep_event     = 1'b1;
            end else begin
                w_rep_nxt = w_rep_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep       <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep       <= w_rep_nxt;
            r_rep_first <= w_rep_first_nxt;
        end
    end

    assign w_event = w_press_event | w_rep_event;
`else
    assign w_event = w_press_event;
`endif

    // Holding register. The event code is the candidate being confirmed
    // (or, for a single-frame debounce, the code arriving from IDLE).
    assign w_handshake = r_key_valid & key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid   <= 1'b0;
            r_key_code    <= '0;
            r_key_overrun <= 1'b0;
        end else begin
            r_key_overrun <= 1'b0;
            if (w_event) begin
                if (r_key_valid && !w_handshake) begin
                    r_key_overrun <= 1'b1;
                end else begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_cand_nxt;
                end
            end else if (w_handshake) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_overrun = r_key_overrun;
    assign key_down    = (r_state == PRESSED) || (r_state == REL_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed and randomised frame-level stimulus for keypad_scanner, 4x4
// matrix, SCAN_DIV=4, DEB_FRAMES=3. A resistive keypad model drives filas
// from the set of pressed keys and the live column strobes. Key sets change
// only at frame starts; after every frame the outputs are compared against
// a frame-level reference built from the press/release rules.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int N_ROWS     = 4;
    localparam int N_COLS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DEB        = 3;
    localparam int REP_DELAY  = 4;
    localparam int REP_RATE   = 2;
    localparam int FRAME_CLKS = N_COLS * SCAN_DIV;
    localparam int NKEYS      = N_ROWS * N_COLS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_ready = 1'b1;
    logic [N_ROWS-1:0] filas;
    logic [N_COLS-1:0] columnas;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_down;
    logic              key_overrun;
    logic [NKEYS-1:0]  keys = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state (frame level)
    bit m_down;
    int m_cand;
    int m_run;
    int m_rel;
    int m_rep;
    bit m_hv;
    int m_hc;
    bit m_ovr;

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low whenever column c is strobed.
    always_comb begin
        filas = '1;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (keys[r*N_COLS + c] && !columnas[c]) filas[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .N_ROWS     (N_ROWS),
        .N_COLS     (N_COLS),
        .SCAN_DIV   (SCAN_DIV),
        .DEB_FRAMES (DEB),
        .REP_DELAY  (REP_DELAY),
        .REP_RATE   (REP_RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .filas       (filas),
        .columnas    (columnas),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_down    (key_down),
        .key_overrun (key_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down = 0; m_cand = 0; m_run = 0; m_rel = 0; m_rep = 0;
        m_hv = 0; m_hc = 0; m_ovr = 0;
    endtask

    // One frame with key set k: a single key is a clean read, anything else
    // (nothing, or ghosting several keys) counts as no key.
    task automatic model_frame(input logic [NKEYS-1:0] k, output bit ev, output int code);
        bit one;
        int kc;
        one = ($countones(k) == 1);
        kc  = 0;
        for (int i = 0; i < NKEYS; i++) if (k[i]) kc = i;
        ev = 0;
        if (!m_down) begin
            if (one && m_run > 0 && kc == m_cand) m_run++;
            else if (one && m_run == 0) begin m_cand = kc; m_run = 1; end
            else m_run = 0;
            if (m_run == DEB) begin
                m_down = 1; ev = 1; m_rel = 0; m_rep = 0;
            end
        end else begin
            if (one && kc == m_cand) begin
                if (m_rel > 0) begin
                    m_rel = 0; m_rep = 0;
                end else begin
                    m_rep++;
`ifdef KPD_REPEAT_EN
                    if (m_rep == REP_DELAY ||
                        (m_rep > REP_DELAY && (m_rep - REP_DELAY) % REP_RATE == 0)) ev = 1;
`endif
                end
            end else begin
                m_rel++;
                if (m_rel == DEB) begin
                    m_down = 0; m_run = 0; m_rel = 0;
                end
            end
        end
        code = m_cand;
    endtask

    // Called at the start of a frame (just after the edge closing the previous one).
    task automatic frame(input logic [NKEYS-1:0] k, input bit rdy);
        bit ev;
        int c;
        keys      = k;
        key_ready = rdy;
        if (rdy) m_hv = 0;  // pending event is taken on the first clock of the frame
        repeat (FRAME_CLKS) @(posedge clk);
        #1;
        model_frame(k, ev, c);
        m_ovr = 0;
        if (ev) begin
            if (m_hv) m_ovr = 1;
            else begin m_hv = 1; m_hc = c; end
        end
        check("key_valid",   key_valid,   m_hv);
        check("key_code",    key_code,    m_hc);
        check("key_down",    key_down,    m_down);
        check("key_overrun", key_overrun, m_ovr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_columnas", columnas,    4'hF);
        check("rst_valid",    key_valid,   1'b0);
        check("rst_code",     key_code,    4'h0);
        check("rst_down",     key_down,    1'b0);
        check("rst_overrun",  key_overrun, 1'b0);
        model_reset();
        rst = 1'b0;
    endtask

    function automatic logic [NKEYS-1:0] key(input int idx);
        logic [NKEYS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [NKEYS-1:0] k;
        int sel;
        int a;
        int b;
        int len;
        bit rdy;

        model_reset();
        do_reset();

        // Clean press of row1/col2 held 6 frames, then release
        for (int f = 0; f < 6; f++) frame(key(6), 1'b1);
        for (int f = 0; f < 3; f++) frame('0, 1'b1);

        // Bouncing key 6 never reaches three consecutive frames
        frame(key(6), 1'b1);
        frame(key(6), 1'b1);
        frame('0, 1'b1);
        frame(key(6), 1'b1);
        frame(key(6), 1'b1);
        for (int f = 0; f < 3; f++) frame('0, 1'b1);

        // Two keys in column 0 (rows 0 and 1) are rejected
        for (int f = 0; f < 10; f++) frame(key(0) | key(4), 1'b1);
        frame('0, 1'b1);

        // Consumer stalled: second press overruns, first code is kept
        for (int f = 0; f < 3; f++) frame(key(5), 1'b0);
        for (int f = 0; f < 3; f++) frame('0, 1'b0);
        for (int f = 0; f < 3; f++) frame(key(9), 1'b0);
        for (int f = 0; f < 3; f++) frame('0, 1'b0);
        frame('0, 1'b1);

        // Reset in the middle of debouncing key 3
        frame(key(3), 1'b1);
        frame(key(3), 1'b1);
        do_reset();
        for (int f = 0; f < 3; f++) frame(key(3), 1'b1);
        for (int f = 0; f < 3; f++) frame('0, 1'b1);

`ifdef KPD_REPEAT_EN
        // Long hold of key 15 for auto-repeat
        for (int f = 0; f < 12; f++) frame(key(15), 1'b1);
        for (int f = 0; f < 3; f++) frame('0, 1'b1);
`endif

        // Random segments: single keys, idle, ghost pairs, random stalls
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 99);
            k   = '0;
            if (sel < 55) begin
                k[$urandom_range(0, NKEYS-1)] = 1'b1;
            end else if (sel >= 80) begin
                a = $urandom_range(0, NKEYS-1);
                b = (a + $urandom_range(1, NKEYS-1)) % NKEYS;
                k[a] = 1'b1;
                k[b] = 1'b1;
            end
            len = $urandom_range(1, 6);
            for (int f = 0; f < len; f++) begin
                rdy = ($urandom_range(0, 9) < 8);
                frame(k, rdy);
            end
        end
        for (int f = 0; f < 4; f++) frame('0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
